// File: rtl/mem_pkg.sv
// Shared definitions for the load/store path: funct3 width codes, FSM state
// encoding, default data width and the request legality check.
package mem_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } mau_state_e;

    // 1 when the request cannot be executed: unknown width code or an address
    // that is not naturally aligned for the access width. The 11x codes fall
    // into the default branch, which covers them for loads and stores alike.
    function automatic logic req_illegal(input logic [2:0] funct3,
                                         input logic [1:0] off);
        logic bad;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extraction: selects the byte/halfword lane of a RAM
// word and sign- or zero-extends it according to funct3.
// Ports:
//   word_i   - full RAM word
//   funct3_i - RISC-V load width/sign code
//   off_i    - byte offset addr[1:0]
//   ext_o    - extended load value
module load_extend
    import mem_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    output logic [XLEN-1:0] ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = word_i[{off_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    ext_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_H:    ext_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_BU:   ext_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_HU:   ext_o = {{(XLEN-16){1'b0}}, half_sel};
            default: ext_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the multi-cycle datapath and a word-organised RAM
// with a registered read port and a whole-word write enable. Sub-word stores
// are done as read-modify-write.
// Ports:
//   clk_i, reset_i        - clock, async active-high reset
//   req_i, we_i, funct3_i - request strobe, store flag, width/sign code
//   addr_i, wdata_i       - byte address, store data (lane from low bits)
//   ready_o, done_o       - idle indication, one-cycle completion pulse
//   rdata_o, err_o        - extended load data / error flag, valid with done_o
//   ram_we_o, ram_a_o     - RAM write enable, word-aligned RAM address
//   ram_wd_o, ram_rd_i    - RAM write data, RAM registered read data
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            ready_o,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            err_o,
    output logic            ram_we_o,
    output logic [XLEN-1:0] ram_a_o,
    output logic [XLEN-1:0] ram_wd_o,
    input  logic [XLEN-1:0] ram_rd_i
);

    mau_state_e      state_q;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic            ram_we_q;
    logic [XLEN-1:0] ram_a_q;
    logic [XLEN-1:0] ram_wd_q;   // doubles as the merge register for sb/sh

    logic            req_bad;
    logic [4:0]      lane_shift;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] lane_data;
    logic [XLEN-1:0] merge_d;
    logic [XLEN-1:0] rdata_d;

    assign req_bad = req_illegal(funct3_i, addr_i[1:0]);

    // funct3[0] separates halfword (x01) from byte (x00) stores; word stores
    // never reach the merge path.
    always_comb begin
        lane_shift = funct3_q[0] ? {off_q[1], 4'b0000} : {off_q, 3'b000};
        lane_mask  = funct3_q[0] ? (XLEN'(16'hFFFF) << lane_shift)
                                 : (XLEN'(8'hFF) << lane_shift);
        lane_data  = funct3_q[0] ? (XLEN'(wdata_q[15:0]) << lane_shift)
                                 : (XLEN'(wdata_q[7:0]) << lane_shift);
        merge_d    = (ram_rd_i & ~lane_mask) | lane_data;
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .word_i   (ram_rd_i),
        .funct3_i (funct3_q),
        .off_i    (off_q),
        .ext_o    (rdata_d)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            ram_we_q <= 1'b0;
            ram_a_q  <= '0;
            ram_wd_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        we_q     <= we_i;
                        funct3_q <= funct3_i;
                        off_q    <= addr_i[1:0];
                        wdata_q  <= wdata_i;
                        rdata_q  <= '0;
                        err_q    <= req_bad;
                        ram_a_q  <= {addr_i[XLEN-1:2], 2'b00};
                        if (req_bad) begin
                            state_q <= ST_DONE;
                        end else if (we_i && funct3_i == F3_W) begin
                            // Full-word store needs no read, write right away.
                            ram_wd_q <= wdata_i;
                            ram_we_q <= 1'b1;
                            state_q  <= ST_WRITE;
                        end else begin
                            state_q <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (we_q) begin
                        ram_wd_q <= merge_d;
                        ram_we_q <= 1'b1;
                        state_q  <= ST_WRITE;
                    end else begin
                        rdata_q <= rdata_d;
                        state_q <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    ram_we_q <= 1'b0;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    ram_we_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign ram_we_o = ram_we_q;
    assign ram_a_o  = ram_a_q;
    assign ram_wd_o = ram_wd_q;

endmodule
